// File: rtl/stream_mux_rr_if.sv
// Bundle of the stream mux's channel-side and output-side handshake signals.
// The slave modport is the mux; the master modport drives the channels and sinks the output.
interface stream_mux_rr_if #(
    parameter int unsigned K  = 1,
    parameter int unsigned N  = 8,
    parameter int unsigned SW = 3
);
    logic [N*K-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel;
    logic           mode;
    logic [K-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_valid;
    logic           out_ready;
    logic [15:0]    xfer_cnt;

    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_sel, out_valid, xfer_cnt
    );

    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_sel, out_valid, xfer_cnt
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux into a single registered output stage with a handshake counter.
// Define STREAM_MUX_RR_EN to build round-robin mode; otherwise selection is always fixed by sel.
module stream_mux_rr #(
    parameter int unsigned K  = 1,
    parameter int unsigned N  = 8,
    parameter int unsigned SW = 3
) (
    input logic            clk,
    input logic            rst_n,
    stream_mux_rr_if.slave bus
);
    localparam logic [SW:0] NUM_CH = (SW+1)'(N);

    logic [K-1:0]  r_out_data;
    logic [SW-1:0] r_out_sel;
    logic          r_out_valid;
    logic [15:0]   r_xfer_cnt;

    logic          w_load;
    logic          w_chosen;
    logic          w_accept;
    logic [SW-1:0] w_c;
    logic [K-1:0]  w_data;
    logic [N-1:0]  w_in_ready;

    assign w_load = !r_out_valid || bus.out_ready;

`ifdef STREAM_MUX_RR_EN
    logic [SW-1:0] r_ptr;
    logic [SW-1:0] w_rr_c;
    logic          w_rr_found;
    logic [SW:0]   w_idx;

    // Search downward from the farthest offset so the nearest valid channel after ptr wins.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_c     = '0;
        w_idx      = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_ptr} + (SW+1)'(i);
            if (w_idx >= NUM_CH) begin
                w_idx = w_idx - NUM_CH;
            end
            if (bus.in_valid[w_idx[SW-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_c     = w_idx[SW-1:0];
            end
        end
    end

    always_comb begin
        w_chosen = ({1'b0, bus.sel} < NUM_CH);
        w_c      = bus.sel;
        if (bus.mode) begin
            w_chosen = w_rr_found;
            w_c      = w_rr_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_accept && bus.mode) begin
            r_ptr <= (w_c == SW'(N - 1)) ? '0 : w_c + SW'(1);
        end
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = bus.mode;

    always_comb begin
        w_chosen = ({1'b0, bus.sel} < NUM_CH);
        w_c      = bus.sel;
    end
`endif

    always_comb begin
        w_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_c == SW'(i)) begin
                w_data = bus.in_data[i*K +: K];
            end
        end
    end

    // Only the chosen channel sees ready, and only when the output stage can load.
    assign w_in_ready = (w_chosen && w_load) ? (N'(1) << w_c) : '0;
    assign w_accept   = |(bus.in_valid & w_in_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_xfer_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_out_data  <= w_data;
                r_out_sel   <= w_c;
                r_out_valid <= 1'b1;
            end else if (w_load) begin
                r_out_valid <= 1'b0;
            end
            if (r_out_valid && bus.out_ready) begin
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.xfer_cnt  = r_xfer_cnt;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed vector table, scoreboarded streams, N=6 select bound,
// async reset and 16-bit counter wrap. Round-robin sequences run when STREAM_MUX_RR_EN is defined.
module tb_stream_mux_rr;
    localparam int unsigned K  = 8;
    localparam int unsigned N  = 8;
    localparam int unsigned N6 = 6;
    localparam int unsigned SW = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic rst6_n;

    always #5 clk = ~clk;

    stream_mux_rr_if #(.K(K), .N(N),  .SW(SW)) bus  ();
    stream_mux_rr_if #(.K(K), .N(N6), .SW(SW)) bus6 ();

    stream_mux_rr #(.K(K), .N(N),  .SW(SW)) u_dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
    stream_mux_rr #(.K(K), .N(N6), .SW(SW)) u_dut6 (.clk(clk), .rst_n(rst6_n), .bus(bus6));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [SW-1:0] sel;
        logic [N-1:0]  vld;
        logic [N-1:0]  exp_ir;
        logic          exp_ov;
        logic [K-1:0]  exp_od;
        logic [SW-1:0] exp_os;
    } vec_t;

    typedef struct {
        logic [K-1:0]  d;
        logic [SW-1:0] s;
    } exp_t;

    vec_t tbl [8];
    exp_t sbq [$];

    logic          m_valid;
    logic [15:0]   m_cnt;
    logic [SW-1:0] m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void choose(input logic md, input logic [SW-1:0] s, input logic [N-1:0] v,
                                   input logic [SW-1:0] p, output logic ch, output logic [SW-1:0] c);
        ch = 1'b1;
        c  = s;
`ifdef STREAM_MUX_RR_EN
        if (md) begin
            ch = 1'b0;
            c  = '0;
            for (int k = int'(N) - 1; k >= 0; k--) begin
                int idx;
                idx = (int'(p) + k) % int'(N);
                if (v[idx]) begin
                    ch = 1'b1;
                    c  = SW'(idx);
                end
            end
        end
`else
        if (md && p != p) ch = 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_cnt   = '0;
        m_ptr   = '0;
        sbq.delete();
    endfunction

    // One clock with model prediction; inputs must already be driven for this cycle.
    task automatic cycle();
        logic          ch, ld, acc, hs, md;
        logic [SW-1:0] c;
        logic [N-1:0]  exp_ir;
        exp_t          e;
        #1;
        md = bus.mode;
        choose(md, bus.sel, bus.in_valid, m_ptr, ch, c);
        ld     = !m_valid || bus.out_ready;
        exp_ir = (ch && ld) ? (N'(1) << c) : '0;
        acc    = ch && ld && bus.in_valid[c];
        hs     = m_valid && bus.out_ready;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (hs) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: handshake with no expected word at %0t", $time);
            end else begin
                e = sbq.pop_front();
                chk("sb_data", 32'(bus.out_data), 32'(e.d));
                chk("sb_sel", 32'(bus.out_sel), 32'(e.s));
            end
        end
        if (acc) begin
            e.d = bus.in_data[int'(c)*K +: K];
            e.s = c;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (hs) m_cnt = m_cnt + 16'd1;
        if (acc) m_valid = 1'b1;
        else if (ld) m_valid = 1'b0;
`ifdef STREAM_MUX_RR_EN
        if (acc && md) m_ptr = (c == SW'(N - 1)) ? '0 : c + SW'(1);
`endif
        chk("xfer_cnt", 32'(bus.xfer_cnt), 32'(m_cnt));
    endtask

    task automatic set_default_data();
        for (int i = 0; i < int'(N); i++) bus.in_data[i*K +: K] = K'(8'hA0 + i);
    endtask

    initial begin
        logic [SW-1:0] rr_seq [5];

        tbl[0] = '{sel: 3'd5, vld: 8'h20, exp_ir: 8'h20, exp_ov: 1'b1, exp_od: 8'hA5, exp_os: 3'd5};
        tbl[1] = '{sel: 3'd2, vld: 8'h20, exp_ir: 8'h04, exp_ov: 1'b0, exp_od: 8'hA5, exp_os: 3'd5};
        tbl[2] = '{sel: 3'd2, vld: 8'h04, exp_ir: 8'h04, exp_ov: 1'b1, exp_od: 8'hA2, exp_os: 3'd2};
        tbl[3] = '{sel: 3'd0, vld: 8'hFF, exp_ir: 8'h01, exp_ov: 1'b1, exp_od: 8'hA0, exp_os: 3'd0};
        tbl[4] = '{sel: 3'd7, vld: 8'h80, exp_ir: 8'h80, exp_ov: 1'b1, exp_od: 8'hA7, exp_os: 3'd7};
        tbl[5] = '{sel: 3'd7, vld: 8'h00, exp_ir: 8'h80, exp_ov: 1'b0, exp_od: 8'hA7, exp_os: 3'd7};
        tbl[6] = '{sel: 3'd3, vld: 8'hF7, exp_ir: 8'h08, exp_ov: 1'b0, exp_od: 8'hA7, exp_os: 3'd7};
        tbl[7] = '{sel: 3'd1, vld: 8'h02, exp_ir: 8'h02, exp_ov: 1'b1, exp_od: 8'hA1, exp_os: 3'd1};

        rst_n = 1'b0;
        rst6_n = 1'b0;
        bus.in_valid = '0;
        bus.sel = '0;
        bus.mode = 1'b0;
        bus.out_ready = 1'b0;
        set_default_data();
        bus6.in_valid = '0;
        bus6.sel = '0;
        bus6.mode = 1'b0;
        bus6.out_ready = 1'b0;
        for (int i = 0; i < int'(N6); i++) bus6.in_data[i*K +: K] = K'(8'hB0 + i);
        model_reset();

        // Reset values before any clock edge
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        chk("rst_out_sel", 32'(bus.out_sel), 32'h0);
        chk("rst_xfer_cnt", 32'(bus.xfer_cnt), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h01);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rst6_n = 1'b1;
        bus.out_ready = 1'b1;

        // Directed fixed-mode vectors with out_ready held high
        for (int r = 0; r < 8; r++) begin
            bus.sel = tbl[r].sel;
            bus.in_valid = tbl[r].vld;
            #1;
            chk($sformatf("tbl%0d_in_ready", r), 32'(bus.in_ready), 32'(tbl[r].exp_ir));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", r), 32'(bus.out_valid), 32'(tbl[r].exp_ov));
            chk($sformatf("tbl%0d_out_data", r), 32'(bus.out_data), 32'(tbl[r].exp_od));
            chk($sformatf("tbl%0d_out_sel", r), 32'(bus.out_sel), 32'(tbl[r].exp_os));
        end
        bus.in_valid = '0;
        @(posedge clk);
        #1;
        chk("tbl_drain_valid", 32'(bus.out_valid), 32'h0);
        chk("tbl_xfer_cnt", 32'(bus.xfer_cnt), 32'd5);
        m_valid = 1'b0;
        m_cnt = 16'd5;

        // Backpressure: hold a word for 3 stalled cycles, then stream the next on release
        bus.sel = 3'd2;
        bus.in_valid = 8'h04;
        cycle();
        bus.out_ready = 1'b0;
        bus.in_data[2*K +: K] = 8'h5A;
        repeat (3) begin
            cycle();
            chk("stall_data", 32'(bus.out_data), 32'hA2);
        end
        bus.out_ready = 1'b1;
        cycle();
        chk("release_data", 32'(bus.out_data), 32'h5A);
        chk("release_valid", 32'(bus.out_valid), 32'h1);
        bus.in_valid = '0;
        cycle();

        // Random fixed-mode stream
        for (int t = 0; t < 300; t++) begin
            bus.mode = 1'b0;
            bus.sel = SW'($urandom_range(0, N - 1));
            bus.in_valid = N'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_data = {$urandom, $urandom};
            cycle();
        end
        bus.in_valid = '0;
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        set_default_data();

`ifdef STREAM_MUX_RR_EN
        // Round-robin order from ptr=0 with channels 0, 4 and 7 requesting
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        rr_seq[0] = 3'd0; rr_seq[1] = 3'd4; rr_seq[2] = 3'd7; rr_seq[3] = 3'd0; rr_seq[4] = 3'd4;
        bus.mode = 1'b1;
        bus.in_valid = 8'h91;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk($sformatf("rr_seq%0d", i), 32'(bus.out_sel), 32'(rr_seq[i]));
        end
        for (int t = 0; t < 300; t++) begin
            bus.mode = ($urandom_range(0, 3) != 0);
            bus.sel = SW'($urandom_range(0, N - 1));
            bus.in_valid = N'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_data = {$urandom, $urandom};
            cycle();
        end
`else
        // mode is ignored: only the selected channel is ever taken
        rr_seq[0] = 3'd3;
        bus.mode = 1'b1;
        bus.sel = 3'd3;
        bus.in_valid = 8'hFF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk($sformatf("fixed_only_sel%0d", i), 32'(bus.out_sel), 32'(rr_seq[0]));
        end
`endif
        bus.in_valid = '0;
        bus.mode = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        cycle();

        // N=6: out-of-range select chooses nothing
        bus6.sel = 3'd0;
        bus6.in_valid = 6'h01;
        bus6.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("n6_out_valid", 32'(bus6.out_valid), 32'h1);
        chk("n6_out_data", 32'(bus6.out_data), 32'hB0);
        bus6.sel = 3'd7;
        bus6.in_valid = 6'h3F;
        #1;
        chk("n6_sel7_in_ready", 32'(bus6.in_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("n6_sel7_out_valid", 32'(bus6.out_valid), 32'h0);
        chk("n6_sel7_xfer_cnt", 32'(bus6.xfer_cnt), 32'h1);
        chk("n6_sel7_out_sel", 32'(bus6.out_sel), 32'h0);
        bus6.sel = 3'd6;
        #1;
        chk("n6_sel6_in_ready", 32'(bus6.in_ready), 32'h0);

        // Counter to 0xFFFF on both instances, then async reset one and wrap the other
        rst_n = 1'b0;
        rst6_n = 1'b0;
        #1;
        rst_n = 1'b1;
        rst6_n = 1'b1;
        @(posedge clk);
        #1;
        bus.in_data[5*K +: K] = 8'hC3;
        bus.sel = 3'd5;
        bus.in_valid = 8'h20;
        bus.out_ready = 1'b1;
        bus6.sel = 3'd0;
        bus6.in_valid = 6'h01;
        bus6.out_ready = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        chk("cnt_ffff", 32'(bus.xfer_cnt), 32'hFFFF);
        chk("cnt_ffff_valid", 32'(bus.out_valid), 32'h1);
        chk("cnt_ffff_data", 32'(bus.out_data), 32'hC3);
        chk("n6_cnt_ffff", 32'(bus6.xfer_cnt), 32'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("async_rst_data", 32'(bus.out_data), 32'h0);
        chk("async_rst_sel", 32'(bus.out_sel), 32'h0);
        chk("async_rst_cnt", 32'(bus.xfer_cnt), 32'h0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'h20);
        @(posedge clk);
        #1;
        chk("n6_cnt_wrap", 32'(bus6.xfer_cnt), 32'h0);
        chk("n6_wrap_valid", 32'(bus6.out_valid), 32'h1);
        chk("held_rst_valid", 32'(bus.out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
